// File: rtl/disp_filter_pkg.sv
// Shared defaults and types for the disparity filtering path.
package disp_filter_pkg;

  localparam int DISP_BITS_DEFAULT = 5;
  localparam int CONF_BITS_DEFAULT = 4;
  localparam int WIN_DEFAULT       = 16;

  // The sum of up to 255 total confidence times disparity fits in 8+disp_bits bits.
  function automatic int conf_disp_w(input int disp_bits);
    return 8 + disp_bits;
  endfunction

  typedef struct packed {
    logic [CONF_BITS_DEFAULT-1:0]                   conf;
    logic [CONF_BITS_DEFAULT+DISP_BITS_DEFAULT-1:0] prod;
  } hist_entry_t;

endpackage

// File: rtl/conf_disp_window_shift.sv
// Window history: a win-deep shift register with enable, sync clear-and-load, tap at win-1.
module conf_disp_window_shift #(
  parameter int WIN = 16,
  parameter int W   = 13
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] tap
);

  logic [WIN-1:0][W-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else if (en) begin
      // On clr, older slots are zeroed so a new row never sees the previous one.
      for (int i = WIN - 1; i > 0; i--) sr[i] <= clr ? '0 : sr[i-1];
      sr[0] <= din;
    end
  end

  assign tap = sr[WIN-1];

endmodule

// File: rtl/conf_disp_accumulate.sv
// Sliding-window sum of conf and conf*disp over the current row; feeds the weighted divide.
module conf_disp_accumulate
  import disp_filter_pkg::*;
#(
  parameter int disp_bits = DISP_BITS_DEFAULT,
  parameter int conf_bits = CONF_BITS_DEFAULT,
  parameter int win       = WIN_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [disp_bits-1:0]           in_disp,
  input  logic [conf_bits-1:0]           in_conf,
  input  logic                           in_sol,
  input  logic                           in_valid,
  output logic [7:0]                     out_conf,
  output logic [conf_disp_w(disp_bits)-1:0] out_conf_disp,
  output logic                           out_valid
);

  localparam int PW     = conf_bits + disp_bits;
  localparam int CDW    = conf_disp_w(disp_bits);
  localparam int STAGES = 2;

  if (win * ((1 << conf_bits) - 1) > 255) begin : g_param_chk
    $error("conf_disp_accumulate: win*(2^conf_bits-1) must not exceed 255");
  end

  typedef struct packed {
    logic [conf_bits-1:0] conf;
    logic [PW-1:0]        prod;
  } entry_t;

  entry_t            s1_e;
  entry_t            tap;
  logic              s1_sol;
  logic [STAGES:1]   vld_pipe;
  logic [7:0]        sum_c;
  logic [CDW-1:0]    sum_p;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_e     <= '0;
      s1_sol   <= 1'b0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      if (in_valid) begin
        s1_e.conf <= in_conf;
        s1_e.prod <= PW'(in_disp) * PW'(in_conf);
        s1_sol    <= in_sol;
      end
    end
  end

  conf_disp_window_shift #(
    .WIN (win),
    .W   ($bits(entry_t))
  ) u_hist (
    .clk   (clk),
    .reset (reset),
    .en    (vld_pipe[1]),
    .clr   (s1_sol),
    .din   (s1_e),
    .tap   (tap)
  );

  // Modular add/sub is exact: the true running sums never leave their ranges.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_c <= '0;
      sum_p <= '0;
    end else if (vld_pipe[1]) begin
      if (s1_sol) begin
        sum_c <= 8'(s1_e.conf);
        sum_p <= CDW'(s1_e.prod);
      end else begin
        sum_c <= sum_c + 8'(s1_e.conf) - 8'(tap.conf);
        sum_p <= sum_p + CDW'(s1_e.prod) - CDW'(tap.prod);
      end
    end
  end

  assign out_conf      = sum_c;
  assign out_conf_disp = sum_p;
  assign out_valid     = vld_pipe[STAGES];

endmodule

// File: tb/tb_conf_disp_accumulate.sv
// Randomized + directed bench for conf_disp_accumulate against a row-queue reference model.
module tb_conf_disp_accumulate;

  localparam int DB = 5;
  localparam int CB = 4;
  localparam int W  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [DB-1:0] in_disp;
  logic [CB-1:0] in_conf;
  logic          in_sol;
  logic          in_valid;
  logic [7:0]    out_conf;
  logic [12:0]   out_conf_disp;
  logic          out_valid;

  conf_disp_accumulate #(.disp_bits(DB), .conf_bits(CB), .win(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_disp       (in_disp),
    .in_conf       (in_conf),
    .in_sol        (in_sol),
    .in_valid      (in_valid),
    .out_conf      (out_conf),
    .out_conf_disp (out_conf_disp),
    .out_valid     (out_valid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pixels of the current row, newest at the back.
  int row_c[$];
  int row_p[$];
  bit pend_v;
  int pend_c, pend_p;
  bit exp_v;
  int exp_c, exp_p;

  always @(posedge clk) begin
    if (reset) begin
      row_c.delete(); row_p.delete();
      pend_v = 0; pend_c = 0; pend_p = 0;
      exp_v = 0; exp_c = 0; exp_p = 0;
    end else begin
      exp_v = pend_v;
      if (pend_v) begin
        exp_c = pend_c;
        exp_p = pend_p;
      end
      pend_v = in_valid;
      if (in_valid) begin
        if (in_sol) begin
          row_c.delete(); row_p.delete();
        end
        row_c.push_back(int'(in_conf));
        row_p.push_back(int'(in_conf) * int'(in_disp));
        if (row_c.size() > W) begin
          void'(row_c.pop_front());
          void'(row_p.pop_front());
        end
        pend_c = 0; pend_p = 0;
        foreach (row_c[i]) begin
          pend_c += row_c[i];
          pend_p += row_p[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", int'(out_valid), int'(exp_v));
      chk("out_conf", int'(out_conf), exp_c);
      chk("out_conf_disp", int'(out_conf_disp), exp_p);
    end
  end

  task automatic px(input bit v, input bit sol, input int d, input int c);
    @(negedge clk);
    in_valid = v;
    in_sol   = sol;
    in_disp  = DB'(d);
    in_conf  = CB'(c);
  endtask

  task automatic idle();
    px(1'b0, 1'b0, 0, 0);
  endtask

  task automatic lit(input string nm, input int v, input int c, input int p);
    chk({nm, "_valid"}, int'(out_valid), v);
    chk({nm, "_conf"}, int'(out_conf), c);
    chk({nm, "_cd"}, int'(out_conf_disp), p);
  endtask

  initial begin
    reset = 1'b1; in_valid = 0; in_sol = 0; in_disp = 0; in_conf = 0;
    @(negedge clk);
    chk_en = 1'b1;
    lit("reset", 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // Ramp fill
    px(1, 1, 10, 15); idle(); idle();
    lit("ramp_k0", 1, 15, 150);
    px(1, 0, 10, 15); idle(); idle();
    lit("ramp_k1", 1, 30, 300);
    for (int k = 2; k < 20; k++) px(1, 0, 10, 15);
    idle(); idle();
    lit("ramp_full", 1, 240, 2400);
    idle();
    lit("hold", 0, 240, 2400);

    // Window drain
    for (int k = 0; k < 15; k++) px(1, 0, 10, 0);
    idle(); idle();
    lit("drain15", 1, 15, 150);
    px(1, 0, 10, 0); idle(); idle();
    lit("drain16", 1, 0, 0);

    // Maximum values
    px(1, 1, 31, 15);
    for (int k = 1; k < 16; k++) px(1, 0, 31, 15);
    idle(); idle();
    lit("max", 1, 240, 7440);
    chk("divide", int'(out_conf_disp) / (int'(out_conf) + 1), 30);

    // Line reset
    px(1, 1, 20, 8);
    for (int k = 1; k < 16; k++) px(1, 0, 20, 8);
    idle(); idle();
    lit("line_full", 1, 128, 2560);
    px(1, 1, 3, 2); idle(); idle();
    lit("line_sol", 1, 2, 6);
    px(1, 0, 3, 2); idle(); idle();
    lit("line_next", 1, 4, 12);

    // Back-to-back sol
    px(1, 1, 7, 3); px(1, 1, 9, 5); idle(); idle();
    lit("b2b_sol", 1, 5, 45);

    // Random gaps with spurious sol on idle cycles
    px(1, 1, $urandom_range(0, 31), $urandom_range(0, 15));
    for (int k = 0; k < 600; k++) begin
      bit v;
      v = ($urandom_range(0, 3) != 0);
      px(v, v ? ($urandom_range(0, 24) == 0) : $urandom_range(0, 1),
         $urandom_range(0, 31), $urandom_range(0, 15));
    end
    idle(); idle();

    // Reset mid-row with pixels in flight
    px(1, 1, 20, 8);
    for (int k = 1; k < 16; k++) px(1, 0, 20, 8);
    px(1, 0, 1, 1);
    px(1, 0, 2, 2);
    @(negedge clk);
    reset = 1'b1; in_valid = 0; in_sol = 0;
    @(negedge clk);
    reset = 1'b0;
    lit("rst_mid", 0, 0, 0);
    idle();
    lit("rst_nostale", 0, 0, 0);
    px(1, 0, 5, 4); idle(); idle();
    lit("post_rst", 1, 4, 20);
    idle(); idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conf_disp_accumulate.md
# conf_disp_accumulate

Sliding-window, confidence-weighted disparity accumulator for the disparity filtering path. Per-pixel (disparity, confidence) pairs come in. For the last `win` pixels of the current row, the block emits Σconf and Σ(conf·disp). Its outputs are the numerator and denominator that feed the confidence-weighted divide stage directly. The divide stage produces the smoothed disparity as Σ(conf·disp)/(Σconf+1).

## Interface
Parameters:
- `disp_bits`, 5: disparity width; must match the downstream divide stage.
- `conf_bits`, 4: per-pixel confidence width.
- `win`, 16: horizontal window length in pixels. Must satisfy win·(2^conf_bits−1) ≤ 255; checked at elaboration with `$error`.

Ports (reset reset, synchronous, active-high; clock clk):
- `clk`, input, 1: clock.
- `reset`, input, 1: synchronous, active-high.
- `in_disp`, input, disp_bits: pixel disparity.
- `in_conf`, input, conf_bits: pixel confidence.
- `in_sol`, input, 1: start of line; qualified by `in_valid`. Marks the first pixel of a row.
- `in_valid`, input, 1: input pixel valid.
- `out_conf`, output, 8: Σconf over the window.
- `out_conf_disp`, output, 8+disp_bits: Σ(conf·disp) over the window.
- `out_valid`, output, 1: output valid, one cycle per accepted input pixel.

## Operation
- Window content: the last `win` valid pixels of the current row, including the current pixel. Slots before row start hold zero, so early pixels of a row sum fewer than `win` terms.
- Stage 1 (registered):
  - product p = in_disp·in_conf, width conf_bits+disp_bits.
  - Also registers c = in_conf, sol, valid.
- Stage 2 (registered, only when stage-1 valid):
  - If sol: history cleared to zero, then history[0] ← {c, p}; sum_c ← c; sum_p ← p.
  - Else: sum_c ← sum_c + c − history[win−1].c; sum_p ← sum_p + p − history[win−1].p; history shifts by one, history[0] ← {c, p}.
- Outputs are the stage-2 sum registers. `out_valid` is the stage-2 valid register.
- No saturation logic. The parameter check guarantees sum_c ≤ 255 and sum_p ≤ 255·(2^disp_bits−1), which fits in 8+disp_bits bits.
- Idle cycles (`in_valid`=0):
  - History and sums hold.
  - `out_valid`=0.
  - `out_conf`/`out_conf_disp` hold their last values.
- `in_sol` with `in_valid`=0 is ignored.
- No backpressure. One input pixel per cycle is always accepted.

## Timing
- Latency: 2 cycles from `in_valid` to the matching `out_valid`. Throughput is 1 pixel/cycle.
- Reset:
  - `out_conf`=0, `out_conf_disp`=0, `out_valid`=0.
  - All history slots and both pipeline stages cleared.
  - Reset mid-row drops in-flight pixels. The first pixel after reset sees an empty window, identical to a start-of-line pixel.
- Row boundary: the sol pixel's output contains only that pixel. Nothing from the previous row leaks in, even if the previous row was shorter than `win`.
- Back-to-back sol pixels: each output equals that single pixel.

## Structure
- Package `disp_filter_pkg` holds:
  - `DISP_BITS_DEFAULT`, `CONF_BITS_DEFAULT`, `WIN_DEFAULT`.
  - Sum width function conf_disp_w(disp_bits) = 8+disp_bits.
  - Typedef for a history entry {conf, product}.
- Sub-module `conf_disp_window_shift`: a `win`-deep shift register with enable, synchronous clear, and tap at win−1. This keeps the history separate from the sum arithmetic.
- Estimated RTL size is about 150–250 lines total.

## Test plan
- Ramp fill: sol at pixel 0, 20 pixels with disp=10, conf=15.
  - Pixel k outputs out_conf=15·(k+1) and out_conf_disp=150·(k+1) for k<16.
  - Then 240/2400 constant; out_valid follows in_valid by exactly 2 cycles.
- Window drain: after a full window of disp=10/conf=15, feed conf=0.
  - Sums drop by 15/150 per pixel and reach 0/0 on the 16th zero-conf pixel.
- Maximum values: 16 pixels of disp=31, conf=15.
  - Expect out_conf=240 and out_conf_disp=7440 with no wrap.
  - Compare the result against the divide stage: 7440/241 = 30.
- Line reset: full window of disp=20/conf=8, then sol with disp=3/conf=2.
  - Output 2/6, then the next pixel (disp=3/conf=2) gives 4/12.
- Valid gaps: random `in_valid` gaps, plus `in_sol` asserted during invalid cycles.
  - Sums match a reference model over valid pixels only.
  - Outputs hold during gaps; spurious sol is ignored.
- Reset mid-row: assert reset for 1 cycle with the window full and 2 pixels in flight.
  - Next cycle: outputs 0, out_valid=0, no stale out_valid.
  - First post-reset pixel disp=5/conf=4 gives 4/20.
